// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM sequencing the RV32I-subset datapath.
// Optional CTRL_PERF_CNT_EN adds cycle and retired-instruction counters.
module multicycle_ctrl #(
  parameter int FETCH_WAIT   = 0,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] instr,
  input  logic [4:0]  status,
  output logic        pcsrc,
  output logic        alusrc,
  output logic [3:0]  aluop,
  output logic        memrw,
  output logic        wb,
  output logic        regrw,
  output logic [1:0]  immgen_ctrl,
  output logic        pc_en,
  output logic [2:0]  state,
  output logic        halted,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt,
`endif
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  localparam logic [3:0] A_ADD = 4'b0000;
  localparam logic [3:0] A_SUB = 4'b0001;
  localparam logic [3:0] A_AND = 4'b0010;
  localparam logic [3:0] A_OR  = 4'b0011;
  localparam logic [3:0] A_XOR = 4'b0100;
  localparam logic [3:0] A_SLL = 4'b0101;
  localparam logic [3:0] A_SRL = 4'b0110;
  localparam logic [3:0] A_SRA = 4'b0111;
  localparam logic [3:0] A_SLT = 4'b1000;

  localparam logic [3:0] WAIT_LD = 4'(FETCH_WAIT);
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  op_q;
  logic [2:0]  f3_q;
  logic        f7b5_q;
  logic        illegal_q;

  logic [6:0]  dec_op;
  logic [2:0]  dec_f3;
  logic [6:0]  dec_f7;
  logic        dec_legal;
  logic        is_r, is_i, is_ld, is_st, is_br;
  logic        taken;
  logic        unused_bits;

  assign dec_op = instr[6:0];
  assign dec_f3 = instr[14:12];
  assign dec_f7 = instr[31:25];
  assign unused_bits = ^{instr[24:15], instr[11:7], status[4], status[2]};

  function automatic logic legal_f(
    input logic [6:0] op,
    input logic [2:0] f3,
    input logic [6:0] f7
  );
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R: begin
        ok = (f7 == 7'd0 && f3 != 3'b011) ||
             (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
      end
      OP_I: begin
        case (f3)
          3'b011:  ok = 1'b0;
          3'b001:  ok = (f7 == 7'd0);
          3'b101:  ok = (f7 == 7'd0) || (f7 == F7_ALT);
          default: ok = 1'b1;
        endcase
      end
      OP_LW, OP_SW: ok = (f3 == 3'b010);
      OP_BR: begin
        ok = (f3 == 3'b000) || (f3 == 3'b001) ||
             (f3 == 3'b100) || (f3 == 3'b101);
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // funct7[5] selects SUB only for register-register ops, SRA for both
  function automatic logic [3:0] alu_f(
    input logic [2:0] f3,
    input logic       alt,
    input logic       reg_op
  );
    logic [3:0] op;
    case (f3)
      3'b000:  op = (reg_op && alt) ? A_SUB : A_ADD;
      3'b001:  op = A_SLL;
      3'b010:  op = A_SLT;
      3'b100:  op = A_XOR;
      3'b101:  op = alt ? A_SRA : A_SRL;
      3'b110:  op = A_OR;
      3'b111:  op = A_AND;
      default: op = A_ADD;
    endcase
    return op;
  endfunction

  assign dec_legal = legal_f(dec_op, dec_f3, dec_f7);

  assign is_r  = (op_q == OP_R);
  assign is_i  = (op_q == OP_I);
  assign is_ld = (op_q == OP_LW);
  assign is_st = (op_q == OP_SW);
  assign is_br = (op_q == OP_BR);

  always_comb begin
    taken = 1'b0;
    case (f3_q)
      3'b000:  taken = status[0];
      3'b001:  taken = ~status[0];
      3'b100:  taken = status[1] ^ status[3];
      3'b101:  taken = ~(status[1] ^ status[3]);
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      op_q      <= 7'd0;
      f3_q      <= 3'd0;
      f7b5_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_DECODE) begin
        op_q   <= dec_op;
        f3_q   <= dec_f3;
        f7b5_q <= dec_f7[5];
      end
      if (state_d == S_TRAP) begin
        illegal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pcsrc       = 1'b0;
    alusrc      = 1'b1;
    aluop       = A_ADD;
    memrw       = 1'b0;
    wb          = 1'b1;
    regrw       = 1'b0;
    immgen_ctrl = 2'b00;
    pc_en       = 1'b0;
    halted      = 1'b0;

    // datapath selects hold through EXEC/MEM/WB so the address stays put
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      unique case (1'b1)
        is_r: begin
          alusrc = 1'b1;
          aluop  = alu_f(f3_q, f7b5_q, 1'b1);
        end
        is_i: begin
          alusrc = 1'b0;
          aluop  = alu_f(f3_q, f7b5_q, 1'b0);
        end
        is_ld: begin
          alusrc = 1'b0;
        end
        is_st: begin
          alusrc      = 1'b0;
          immgen_ctrl = 2'b01;
        end
        is_br: begin
          alusrc      = 1'b1;
          aluop       = A_SUB;
          immgen_ctrl = 2'b10;
        end
        default: ;
      endcase
    end

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (cnt_q == 4'd0) state_d = S_DECODE;
        else cnt_d = cnt_q - 4'd1;
      end
      S_DECODE: begin
        if (dec_op == OP_SYS) begin
          state_d = S_HALT;
        end else if (dec_legal) begin
          state_d = S_EXEC;
        end else if (TRAP_ILLEGAL) begin
          state_d = S_TRAP;
        end else begin
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_br) begin
          pc_en   = 1'b1;
          pcsrc   = taken;
          state_d = S_FETCH;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_st) begin
          memrw   = 1'b1;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        regrw   = 1'b1;
        pc_en   = 1'b1;
        wb      = ~is_ld;
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (run) begin
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_TRAP: begin
        halted = 1'b1;
      end
    endcase

    if (state_d == S_FETCH && state_q != S_FETCH) begin
      cnt_d = WAIT_LD;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT && state_q != S_TRAP) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if (pc_en) begin
        instret_cnt <= instret_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed vector bench for multicycle_ctrl.
// Three instances: trap build, NOP build, and FETCH_WAIT=2 build.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic [31:0] instr;
  logic [4:0]  status;

  logic        pcsrc, alusrc, memrw, wb, regrw, pc_en, halted, illegal;
  logic [3:0]  aluop;
  logic [1:0]  immgen_ctrl;
  logic [2:0]  state;

  logic        n_pcsrc, n_alusrc, n_memrw, n_wb, n_regrw;
  logic        n_pc_en, n_halted, n_illegal;
  logic [3:0]  n_aluop;
  logic [1:0]  n_imm;
  logic [2:0]  n_state;

  logic        w_pcsrc, w_alusrc, w_memrw, w_wb, w_regrw;
  logic        w_pc_en, w_halted, w_illegal;
  logic [3:0]  w_aluop;
  logic [1:0]  w_imm;
  logic [2:0]  w_state;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cyc0, ret0, cyc1, ret1, cyc2, ret2;
`endif

  multicycle_ctrl #(.FETCH_WAIT(0), .TRAP_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .status(status),
    .pcsrc(pcsrc), .alusrc(alusrc), .aluop(aluop), .memrw(memrw),
    .wb(wb), .regrw(regrw), .immgen_ctrl(immgen_ctrl), .pc_en(pc_en),
    .state(state), .halted(halted),
`ifdef CTRL_PERF_CNT_EN
    .cycle_cnt(cyc0), .instret_cnt(ret0),
`endif
    .illegal(illegal)
  );

  multicycle_ctrl #(.FETCH_WAIT(0), .TRAP_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .status(status),
    .pcsrc(n_pcsrc), .alusrc(n_alusrc), .aluop(n_aluop),
    .memrw(n_memrw), .wb(n_wb), .regrw(n_regrw),
    .immgen_ctrl(n_imm), .pc_en(n_pc_en),
    .state(n_state), .halted(n_halted),
`ifdef CTRL_PERF_CNT_EN
    .cycle_cnt(cyc1), .instret_cnt(ret1),
`endif
    .illegal(n_illegal)
  );

  multicycle_ctrl #(.FETCH_WAIT(2), .TRAP_ILLEGAL(1'b1)) dut_w (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .status(status),
    .pcsrc(w_pcsrc), .alusrc(w_alusrc), .aluop(w_aluop),
    .memrw(w_memrw), .wb(w_wb), .regrw(w_regrw),
    .immgen_ctrl(w_imm), .pc_en(w_pc_en),
    .state(w_state), .halted(w_halted),
`ifdef CTRL_PERF_CNT_EN
    .cycle_cnt(cyc2), .instret_cnt(ret2),
`endif
    .illegal(w_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRA  = 32'h4020D1B3;
  localparam logic [31:0] I_XORI = 32'h00504093;
  localparam logic [31:0] I_LW   = 32'h0080A283;
  localparam logic [31:0] I_SW   = 32'h0050A623;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BLT  = 32'h0020C463;
  localparam logic [31:0] I_BGE  = 32'h0020D463;
  localparam logic [31:0] I_ECAL = 32'h00000073;
  localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;

  typedef struct {
    bit          chk;
    logic        rst;
    logic        run;
    logic [31:0] instr;
    logic [4:0]  status;
    logic [16:0] exp;
  } vec_t;

  vec_t vq[$];
  int   nvec;
  int   nerr;

  // {state,pcsrc,alusrc,aluop,memrw,wb,regrw,imm,pc_en,halted,illegal}
  function automatic logic [16:0] e(
    input int st, input int pcs, input int als, input int aop,
    input int mrw, input int wbv, input int rrw, input int imm,
    input int pce, input int hlt, input int ill
  );
    return {3'(st), 1'(pcs), 1'(als), 4'(aop), 1'(mrw), 1'(wbv),
            1'(rrw), 2'(imm), 1'(pce), 1'(hlt), 1'(ill)};
  endfunction

  function automatic logic [16:0] d(input int st);
    return e(st, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
  endfunction

  task automatic add(input int c, input int r, input int rn,
                     input logic [31:0] ins, input int sts,
                     input logic [16:0] x);
    vec_t v;
    v.chk    = (c != 0);
    v.rst    = 1'(r);
    v.run    = 1'(rn);
    v.instr  = ins;
    v.status = 5'(sts);
    v.exp    = x;
    vq.push_back(v);
  endtask

  task automatic add_fd(input logic [31:0] ins, input int sts);
    add(1, 0, 0, ins, sts, d(1));
    add(1, 0, 0, ins, sts, d(2));
  endtask

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic rn,
                      input logic [31:0] ins);
    @(negedge clk);
    rst   = r;
    run   = rn;
    instr = ins;
    #1;
  endtask

  logic [16:0] act;

  initial begin
    nvec   = 0;
    nerr   = 0;
    rst    = 1'b1;
    run    = 1'b0;
    instr  = 32'd0;
    status = 5'd0;

    // reset and idle
    add(0, 1, 0, 0, 0, d(0));
    add(1, 1, 0, 0, 0, d(0));
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, d(0));
    // ADD
    add(1, 0, 1, I_ADD, 0, d(0));
    add_fd(I_ADD, 0);
    add(1, 0, 0, I_ADD, 0, e(3, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    add(1, 0, 0, I_ADD, 0, e(5, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0));
    // SUB, SRA
    add_fd(I_SUB, 0);
    add(1, 0, 0, I_SUB, 0, e(3, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
    add(1, 0, 0, I_SUB, 0, e(5, 0, 1, 1, 0, 1, 1, 0, 1, 0, 0));
    add_fd(I_SRA, 0);
    add(1, 0, 0, I_SRA, 0, e(3, 0, 1, 7, 0, 1, 0, 0, 0, 0, 0));
    add(1, 0, 0, I_SRA, 0, e(5, 0, 1, 7, 0, 1, 1, 0, 1, 0, 0));
    // XORI
    add_fd(I_XORI, 0);
    add(1, 0, 0, I_XORI, 0, e(3, 0, 0, 4, 0, 1, 0, 0, 0, 0, 0));
    add(1, 0, 0, I_XORI, 0, e(5, 0, 0, 4, 0, 1, 1, 0, 1, 0, 0));
    // LW
    add_fd(I_LW, 0);
    add(1, 0, 0, I_LW, 0, e(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    add(1, 0, 0, I_LW, 0, e(4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    add(1, 0, 0, I_LW, 0, e(5, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    // SW
    add_fd(I_SW, 0);
    add(1, 0, 0, I_SW, 0, e(3, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    add(1, 0, 0, I_SW, 0, e(4, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0));
    // branches: status = {parity, overflow, cout, n, z}
    add_fd(I_BEQ, 1);
    add(1, 0, 0, I_BEQ, 1, e(3, 1, 1, 1, 0, 1, 0, 2, 1, 0, 0));
    add_fd(I_BEQ, 0);
    add(1, 0, 0, I_BEQ, 0, e(3, 0, 1, 1, 0, 1, 0, 2, 1, 0, 0));
    add_fd(I_BNE, 0);
    add(1, 0, 0, I_BNE, 0, e(3, 1, 1, 1, 0, 1, 0, 2, 1, 0, 0));
    add_fd(I_BLT, 2);
    add(1, 0, 0, I_BLT, 2, e(3, 1, 1, 1, 0, 1, 0, 2, 1, 0, 0));
    add_fd(I_BLT, 10);
    add(1, 0, 0, I_BLT, 10, e(3, 0, 1, 1, 0, 1, 0, 2, 1, 0, 0));
    add_fd(I_BGE, 10);
    add(1, 0, 0, I_BGE, 10, e(3, 1, 1, 1, 0, 1, 0, 2, 1, 0, 0));
    // ECALL -> HALT, resume
    add_fd(I_ECAL, 0);
    add(1, 0, 0, I_ECAL, 0, e(6, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0));
    add(1, 0, 0, I_ECAL, 0, e(6, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0));
    add(1, 0, 1, I_ECAL, 0, e(6, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0));
    // SW interrupted by reset in MEM
    add_fd(I_SW, 0);
    add(1, 0, 0, I_SW, 0, e(3, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    add(1, 1, 0, I_SW, 0, e(4, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0));
    add(1, 0, 0, I_SW, 0, d(0));
    add(1, 0, 0, I_SW, 0, d(0));
    // illegal -> TRAP, sticky until reset
    add(1, 0, 1, I_ILL, 0, d(0));
    add_fd(I_ILL, 0);
    for (int i = 0; i < 10; i++)
      add(1, 0, 1, I_ILL, 0, e(7, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1));
    add(1, 1, 1, I_ILL, 0, e(7, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1));
    add(1, 0, 0, I_ILL, 0, d(0));

    foreach (vq[i]) begin
      @(negedge clk);
      rst    = vq[i].rst;
      run    = vq[i].run;
      instr  = vq[i].instr;
      status = vq[i].status;
      #1;
      act = {state, pcsrc, alusrc, aluop, memrw, wb, regrw,
             immgen_ctrl, pc_en, halted, illegal};
      if (vq[i].chk) begin
        nvec++;
        if (act !== vq[i].exp) begin
          nerr++;
          $display("FAIL vec%0d instr=%h: got %b expected %b",
                   i, vq[i].instr, act, vq[i].exp);
        end
      end
    end

    // NOP build and fetch-wait build on an illegal opcode
    step(1'b1, 1'b0, I_ILL);
    step(1'b1, 1'b0, I_ILL);
    step(1'b0, 1'b1, I_ILL);
    check("nop_s0_state", 32'(n_state), 0);
    check("w_s0_state", 32'(w_state), 0);
    step(1'b0, 1'b0, I_ILL);
    check("nop_s1_state", 32'(n_state), 1);
    check("nop_s1_pc_en", 32'(n_pc_en), 0);
    check("w_s1_state", 32'(w_state), 1);
    step(1'b0, 1'b0, I_ILL);
    check("nop_s2_state", 32'(n_state), 2);
    check("nop_s2_pc_en", 32'(n_pc_en), 1);
    check("nop_s2_pcsrc", 32'(n_pcsrc), 0);
    check("nop_s2_illegal", 32'(n_illegal), 0);
    check("w_s2_state", 32'(w_state), 1);
    step(1'b0, 1'b0, I_ILL);
    check("nop_s3_state", 32'(n_state), 1);
    check("nop_s3_pc_en", 32'(n_pc_en), 0);
    check("w_s3_state", 32'(w_state), 1);
    check("trap_s3_state", 32'(state), 7);
    step(1'b0, 1'b0, I_ILL);
    check("nop_s4_state", 32'(n_state), 2);
    check("w_s4_state", 32'(w_state), 2);
    step(1'b0, 1'b0, I_ILL);
    check("w_s5_state", 32'(w_state), 7);
    check("w_s5_illegal", 32'(w_illegal), 1);
    check("w_s5_halted", 32'(w_halted), 1);
    check("nop_s5_state", 32'(n_state), 1);
    check("nop_s5_halted", 32'(n_halted), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the RV32I-subset datapath: FETCH, DECODE, EXEC, MEM, WB.
- Decodes the datapath `instr` output and drives its control inputs: `pcsrc`, `alusrc`, `aluop`, `memrw`, `wb`, `regrw`, `immgen_ctrl`.
- Adds `pc_en`, which gates the PC register in the datapath revision that integrates this block.
- Resolves branches from the datapath `status` bus.

Parameters:
- FETCH_WAIT, 0: extra wait cycles in FETCH for ROM/decoder settle (0-15).
- TRAP_ILLEGAL, 1: 1 = unknown opcode/funct enters TRAP; 0 = treat it as NOP (advance PC+4).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- run  in  1  leave IDLE / resume from HALT
- instr  in  32  decoded instruction from datapath
- status  in  5  {parity, overflow, cout, n, z}
- pcsrc  out  1  0 = PC+4, 1 = PC+imm
- alusrc  out  1  0 = immediate, 1 = rs2
- aluop  out  4  ALU opcode
- memrw  out  1  1 = RAM write (one cycle)
- wb  out  1  0 = RAM data, 1 = ALU result to register file
- regrw  out  1  register-file write enable
- immgen_ctrl  out  2  00 = I, 01 = S, 10 = B
- pc_en  out  1  PC update strobe
- state  out  3  current FSM state, for debug
- halted  out  1  in HALT or TRAP
- illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Reset, synchronous on rst=1 at the clock edge; this overrides everything, including mid-instruction:
  - state=IDLE, wait counter=0, illegal=0.
  - All strobes 0: regrw, memrw, pc_en.
  - Other outputs: pcsrc=0, alusrc=1, aluop=ADD, wb=1, immgen_ctrl=00.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, TRAP=7.
- aluop encoding: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLL=0101, SRL=0110, SRA=0111, SLT=1000.
- Outside the cycles listed below, regrw, memrw and pc_en are 0; each is asserted for exactly one cycle per instruction.
- IDLE -> FETCH when run=1.
- FETCH:
  - Counter loads FETCH_WAIT and decrements.
  - FETCH -> DECODE when the counter is 0; FETCH_WAIT=0 gives 1 cycle.
- DECODE:
  - Latches opcode/funct3/funct7 into internal registers; control outputs come from the latched fields.
  - -> EXEC for a legal opcode.
  - 1110011 (ECALL/EBREAK) -> HALT.
  - Unknown opcode -> TRAP (illegal=1) if TRAP_ILLEGAL=1, else pc_en=1 with pcsrc=0, then -> FETCH.
- EXEC, by instruction class:
  - R-type (0110011): alusrc=1; aluop from funct3/funct7[5] (SUB when funct7[5]=1 and funct3=000). -> WB.
  - I-ALU (0010011): alusrc=0, immgen_ctrl=00. -> WB.
  - LW (0000011): ADD, alusrc=0, immgen_ctrl=00. -> MEM.
  - SW (0100011): ADD, alusrc=0, immgen_ctrl=01. -> MEM.
  - Branch (1100011): SUB, alusrc=1, immgen_ctrl=10, pc_en=1, pcsrc=taken. -> FETCH.
- Branch taken condition, evaluated combinationally from status in EXEC:
  - BEQ(000): z.
  - BNE(001): !z.
  - BLT(100): n^overflow.
  - BGE(101): !(n^overflow).
  - Any other funct3 is illegal.
- MEM:
  - SW: memrw=1, pc_en=1, pcsrc=0. -> FETCH.
  - LW: address is held (aluop/alusrc unchanged). -> WB.
- WB:
  - regrw=1, pc_en=1, pcsrc=0; wb=0 for LW, 1 otherwise. -> FETCH.
- Latency in cycles with FETCH_WAIT=0: branch 3, R/I 4, SW 4, LW 5.
- run=0 does not stall an instruction already in flight.
- HALT: outputs at reset defaults with halted=1; run=1 -> pc_en pulse (PC+4) -> FETCH.
- TRAP: halted=1, illegal=1; exits only on rst.
- Control outputs stay stable for the whole state, with no glitch between registered state and decode.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- When defined, adds two outputs:
  - cycle_cnt[31:0]: increments every clock while not IDLE/HALT/TRAP.
  - instret_cnt[31:0]: increments on every pc_en.
- Both counters clear on rst and wrap 0xFFFFFFFF -> 0.
- When undefined, the ports and logic are absent and all other behaviour is identical.

Test Plan:
- rst held 2 cycles, then released with run=0: state=0, regrw=memrw=pc_en=0 and aluop=0000 across the reset edges and for 5 further cycles.
- run=1; instr=ADD x3,x1,x2 (0x002081B3): state sequence 1,2,3,5; EXEC aluop=0000, alusrc=1; WB regrw=1, wb=1, pc_en=1; total 4 cycles.
- LW x5,8(x1) (0x0080A283) then SW x5,12(x1) (0x0050A623):
  - LW: states 1,2,3,4,5, with wb=0 in WB.
  - SW: states 1,2,3,4, with memrw=1 only in MEM and immgen_ctrl=01.
- BEQ (0x00208463):
  - with status[0]=1: EXEC pcsrc=1, pc_en=1, aluop=0001, immgen_ctrl=10, 3 cycles total.
  - with status[0]=0: pcsrc=0.
  - BLT with status n=1, o=0: taken.
- instr=0xFFFFFFFF with TRAP_ILLEGAL=1: state=7, illegal=1, halted=1 persist for 10 cycles; rst -> IDLE, illegal=0. With TRAP_ILLEGAL=0: pc_en pulse, then FETCH.
- ECALL 0x00000073: HALT, halted=1; run=1 -> one pc_en with pcsrc=0 -> FETCH. Assert rst during MEM of an SW: memrw=0 from the next cycle onward, state=0.
